// File: rtl/fnv_pkg.sv
// Shared constants, FSM state type and the single-byte FNV-1a update used by
// the scheduler and its hash register.
package fnv_pkg;

    localparam logic [31:0] DEFAULT_OFFSET_BASIS = 32'h811C9DC5;
    localparam logic [31:0] DEFAULT_FNV_PRIME    = 32'h01000193;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HASH = 2'd1,
        DONE = 2'd2
    } state_e;

    // FNV-1a order: xor the byte in first, then multiply (mod 2^32).
    function automatic logic [31:0] fnv_step(input logic [31:0] h,
                                             input logic [7:0]  b,
                                             input logic [31:0] prime);
        logic [31:0] mixed;
        mixed = h ^ {24'b0, b};
        return mixed * prime;
    endfunction

endpackage

// File: rtl/fnv_1a_byte_step.sv
// Running FNV-1a hash register: init/reset reload the offset basis, en folds
// one byte into the hash.
module fnv_1a_byte_step
    import fnv_pkg::*;
#(
    parameter logic [31:0] OFFSET_BASIS = DEFAULT_OFFSET_BASIS,
    parameter logic [31:0] FNV_PRIME    = DEFAULT_FNV_PRIME
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] hash_o
);

    logic [31:0] hash_q;
    logic [31:0] hash_d;

    always_comb begin
        hash_d = hash_q;
        if (init_i) begin
            hash_d = OFFSET_BASIS;
        end else if (en_i) begin
            hash_d = fnv_step(hash_q, byte_i, FNV_PRIME);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hash_q <= OFFSET_BASIS;
        end else begin
            hash_q <= hash_d;
        end
    end

    assign hash_o = hash_q;

endmodule

// File: rtl/fnv_hash_scheduler.sv
// Round-robin, per-message arbiter sharing one byte-serial FNV-1a engine
// between N_REQ byte streams; digests leave on a valid/ready port with an id.
module fnv_hash_scheduler
    import fnv_pkg::*;
#(
    parameter int          N_REQ        = 2,
    parameter logic [31:0] OFFSET_BASIS = DEFAULT_OFFSET_BASIS,
    parameter logic [31:0] FNV_PRIME    = DEFAULT_FNV_PRIME,
    localparam int         ID_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic [31:0]          dig_data,
    output logic [ID_W-1:0]      dig_id,
    output logic                 dig_valid,
    input  logic                 dig_ready,
    output logic                 busy
);

    state_e            state_q;
    logic [ID_W-1:0]   grant_q;
    logic [ID_W-1:0]   grant_d;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   rr_ptr_d;
    logic [N_REQ-1:0]  req_ready_q;
    logic              dig_valid_q;
    logic              busy_q;
    logic              beat;
    logic              digest_taken;
    logic [7:0]        beat_byte;
    logic [31:0]       hash_w;

    // Search from rr_ptr upward with wrap; the loop runs high-to-low so the
    // closest valid requester after rr_ptr is the last (winning) assignment.
    always_comb begin
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] idx;
        grant_d = rr_ptr_q;
        sum     = '0;
        idx     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_REQ)) begin
                sum = sum - (ID_W+1)'(N_REQ);
            end
            idx = sum[ID_W-1:0];
            if (req_valid[idx]) begin
                grant_d = idx;
            end
        end
    end

    assign rr_ptr_d     = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
    assign beat         = req_valid[grant_q] & req_ready_q[grant_q];
    assign beat_byte    = req_data[{grant_q, 3'b000} +: 8];
    assign digest_taken = dig_valid_q & dig_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            req_ready_q <= '0;
            dig_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        grant_q     <= grant_d;
                        req_ready_q <= N_REQ'(1) << grant_d;
                        busy_q      <= 1'b1;
                        state_q     <= HASH;
                    end
                end
                HASH: begin
                    if (beat && req_last[grant_q]) begin
                        req_ready_q <= '0;
                        dig_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (dig_ready) begin
                        dig_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        rr_ptr_q    <= rr_ptr_d;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    req_ready_q <= '0;
                    dig_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    fnv_1a_byte_step #(
        .OFFSET_BASIS (OFFSET_BASIS),
        .FNV_PRIME    (FNV_PRIME)
    ) u_step (
        .clk    (clk),
        .reset  (reset),
        .init_i (digest_taken),
        .en_i   (beat),
        .byte_i (beat_byte),
        .hash_o (hash_w)
    );

    // The hash register only changes on beats, so it is stable throughout DONE.
    assign req_ready = req_ready_q;
    assign dig_valid = dig_valid_q;
    assign dig_data  = dig_valid_q ? hash_w : '0;
    assign dig_id    = dig_valid_q ? grant_q : '0;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fnv_hash_scheduler.sv
// Bench for fnv_hash_scheduler: queued byte streams per requester, a digest
// scoreboard fed from a plain FNV-1a model, and directed ordering scenarios.
`timescale 1ns/1ps
module tb_fnv_hash_scheduler;

    localparam int N = 2;
    localparam logic [31:0] H_A      = 32'hE40C292C;
    localparam logic [31:0] H_B      = 32'hE70C2DE5;
    localparam logic [31:0] H_FOOBAR = 32'hBF9CF968;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [31:0]    dig_data;
    logic [0:0]     dig_id;
    logic           dig_valid;
    logic           dig_ready;
    logic           busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rdy_mode = 0;              // 0: ready high, 1: ready low, 2: random

    logic [9:0]  txq [N][$];       // {bubble, last, byte}
    logic [31:0] expq [N][$];
    int          log_id[$];
    logic [31:0] log_data[$];
    int          hs_count[N];

    fnv_hash_scheduler #(.N_REQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_data  (req_data),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_ready (req_ready),
        .dig_data  (dig_data),
        .dig_id    (dig_id),
        .dig_valid (dig_valid),
        .dig_ready (dig_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] fnv_ref(input logic [7:0] msg[$]);
        logic [31:0] h;
        h = 32'h811C9DC5;
        foreach (msg[i]) h = (h ^ {24'b0, msg[i]}) * 32'h01000193;
        return h;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_msg(input int r, input logic [7:0] msg[$],
                            input int bub_pos, input int bub_len, input bit rnd_bub);
        for (int i = 0; i < msg.size(); i++) begin
            if (i == bub_pos) for (int b = 0; b < bub_len; b++) txq[r].push_back(10'h200);
            if (rnd_bub && $urandom_range(0, 3) == 0)
                for (int b = 0; b <= int'($urandom_range(0, 1)); b++) txq[r].push_back(10'h200);
            txq[r].push_back({1'b0, (i == msg.size() - 1), msg[i]});
        end
        expq[r].push_back(fnv_ref(msg));
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int t = 0;
        while (log_id.size() < n && t < budget) begin
            @(posedge clk);
            t++;
        end
        checks++;
        if (log_id.size() < n) begin
            failures++;
            $display("FAIL %s timeout digests=%0d required=%0d", name, log_id.size(), n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            txq[i].delete();
            expq[i].delete();
        end
        @(posedge clk);
        @(negedge clk);
        check32("rst_req_ready", 32'(req_ready), 0);
        check32("rst_dig_valid", 32'(dig_valid), 0);
        check32("rst_dig_data", dig_data, 0);
        check32("rst_dig_id", 32'(dig_id), 0);
        check32("rst_busy", 32'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Requester drivers: present queue heads, retire them after a handshake.
    initial begin
        logic [N-1:0] hs;
        logic [9:0]   e;
        bit           showing_bub[N];
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        dig_ready = 1'b1;
        forever begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if ((hs[i] || showing_bub[i]) && txq[i].size() > 0) begin
                    void'(txq[i].pop_front());
                    if (hs[i]) hs_count[i]++;
                end
                showing_bub[i] = 1'b0;
                if (txq[i].size() > 0) begin
                    e = txq[i][0];
                    if (e[9]) begin
                        req_valid[i]   = 1'b0;
                        showing_bub[i] = 1'b1;
                    end else begin
                        req_valid[i]      = 1'b1;
                        req_data[8*i +: 8] = e[7:0];
                        req_last[i]       = e[8];
                    end
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
            case (rdy_mode)
                0:       dig_ready = 1'b1;
                1:       dig_ready = 1'b0;
                default: dig_ready = ($urandom_range(0, 99) < 65);
            endcase
        end
    end

    // Per-cycle compare against the scoreboard and protocol rules.
    initial begin
        logic        pv, pr;
        logic [31:0] pd;
        logic [0:0]  pid;
        int          last_cyc;
        pv = 1'b0; pr = 1'b0; pd = '0; pid = '0; last_cyc = -10;
        forever begin
            @(negedge clk);
            if (reset) begin
                pv = 1'b0;
                continue;
            end
            check32("ready_onehot", 32'($countones(req_ready) <= 1), 1);
            if (dig_valid) check32("ready_in_done", 32'(req_ready), 0);
            else check32("dig_data_idle", dig_data, 0);
            if (dig_valid || req_ready != 0) check32("busy_active", 32'(busy), 1);
            if (pv && !pr) begin
                check32("hold_valid", 32'(dig_valid), 1);
                check32("hold_data", dig_data, pd);
                check32("hold_id", 32'(dig_id), 32'(pid));
            end else if (dig_valid) begin
                check32("latency", cyc, last_cyc + 1);
            end
            if (|(req_valid & req_ready & req_last)) last_cyc = cyc;
            if (dig_valid && dig_ready) begin
                checks++;
                if (expq[dig_id].size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_digest actual=id%0d:%h required=none", dig_id, dig_data);
                end else begin
                    check32("digest", dig_data, expq[dig_id].pop_front());
                end
                log_id.push_back(int'(dig_id));
                log_data.push_back(dig_data);
            end
            pv = dig_valid; pr = dig_ready; pd = dig_data; pid = dig_id;
        end
    end

    initial begin
        logic [7:0] m_a[$];
        logic [7:0] m_b[$];
        logic [7:0] m_fb[$];
        logic [7:0] m_r[$];
        int base;
        int t;
        m_a  = '{8'h61};
        m_b  = '{8'h62};
        m_fb = '{8'h66, 8'h6f, 8'h6f, 8'h62, 8'h61, 8'h72};

        check32("model_a", fnv_ref(m_a), H_A);
        check32("model_b", fnv_ref(m_b), H_B);
        check32("model_foobar", fnv_ref(m_fb), H_FOOBAR);

        do_reset();

        // Single byte, immediate accept, busy drops right after the digest.
        base = log_id.size();
        push_msg(0, m_a, -1, 0, 0);
        wait_log(base + 1, 50, "t1_wait");
        @(negedge clk);
        check32("t1_busy_after", 32'(busy), 0);
        check32("t1_valid_after", 32'(dig_valid), 0);
        if (log_id.size() > base) begin
            check32("t1_data", log_data[base], H_A);
            check32("t1_id", 32'(log_id[base]), 0);
        end

        // foobar on req1 with three bubbles before 'b'.
        base = log_id.size();
        push_msg(1, m_fb, 3, 3, 0);
        wait_log(base + 1, 80, "t2_wait");
        if (log_id.size() > base) begin
            check32("t2_data", log_data[base], H_FOOBAR);
            check32("t2_id", 32'(log_id[base]), 1);
        end

        // Fairness: both requesters contend from reset.
        do_reset();
        base = log_id.size();
        push_msg(0, m_a, -1, 0, 0);
        push_msg(0, m_a, -1, 0, 0);
        push_msg(1, m_b, -1, 0, 0);
        push_msg(1, m_b, -1, 0, 0);
        wait_log(base + 4, 100, "t3_wait");
        if (log_id.size() >= base + 4) begin
            for (int k = 0; k < 4; k++) begin
                check32("t3_order", 32'(log_id[base + k]), k % 2);
                check32("t3_data", log_data[base + k], (k % 2) ? H_B : H_A);
            end
        end

        // Consumer stall with a competing requester waiting.
        do_reset();
        rdy_mode = 1;
        base = log_id.size();
        push_msg(0, m_a, -1, 0, 0);
        push_msg(1, m_b, -1, 0, 0);
        t = 0;
        while (!dig_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check32("t4_seen", 32'(dig_valid), 1);
        for (int k = 0; k < 5; k++) begin
            check32("t4_stall_valid", 32'(dig_valid), 1);
            check32("t4_stall_data", dig_data, H_A);
            check32("t4_stall_id", 32'(dig_id), 0);
            check32("t4_stall_ready", 32'(req_ready), 0);
            @(negedge clk);
        end
        rdy_mode = 0;
        wait_log(base + 2, 60, "t4_wait");
        if (log_id.size() >= base + 2) begin
            check32("t4_first", log_data[base], H_A);
            check32("t4_second", log_data[base + 1], H_B);
            check32("t4_second_id", 32'(log_id[base + 1]), 1);
        end

        // Abort mid-message: rr_ptr was advanced to 1, reset must return it to 0.
        do_reset();
        base = log_id.size();
        push_msg(0, m_a, -1, 0, 0);
        wait_log(base + 1, 50, "t5_pre");
        t = hs_count[1];
        push_msg(1, m_fb, -1, 0, 0);
        for (int k = 0; k < 60 && hs_count[1] < t + 3; k++) @(posedge clk);
        check32("t5_three_bytes", 32'(hs_count[1] >= t + 3), 1);
        base = log_id.size();
        do_reset();
        repeat (10) @(posedge clk);
        check32("t5_no_partial", log_id.size(), base);
        push_msg(0, m_a, -1, 0, 0);
        push_msg(1, m_b, -1, 0, 0);
        wait_log(base + 2, 80, "t5_wait");
        if (log_id.size() >= base + 2) begin
            check32("t5_first_id", 32'(log_id[base]), 0);
            check32("t5_first_data", log_data[base], H_A);
            check32("t5_second_data", log_data[base + 1], H_B);
        end

        // Back-to-back on req0: hash must reinitialise between messages.
        base = log_id.size();
        push_msg(0, m_a, -1, 0, 0);
        push_msg(0, m_a, -1, 0, 0);
        wait_log(base + 2, 60, "t6_wait");
        if (log_id.size() >= base + 2) begin
            check32("t6_first", log_data[base], H_A);
            check32("t6_second", log_data[base + 1], H_A);
        end

        // Randomised traffic with random bubbles and consumer back-pressure.
        rdy_mode = 2;
        base = log_id.size();
        for (int m = 0; m < 12; m++) begin
            for (int r = 0; r < N; r++) begin
                m_r.delete();
                for (int b = 0; b < int'($urandom_range(1, 8)); b++) m_r.push_back(8'($urandom_range(0, 255)));
                push_msg(r, m_r, -1, 0, 1);
            end
        end
        wait_log(base + 12 * N, 6000, "rand_wait");
        for (int r = 0; r < N; r++) check32("rand_drained", expq[r].size(), 0);
        rdy_mode = 0;
        repeat (5) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fnv_hash_scheduler.md
Name: fnv_hash_scheduler

Overview:
- Shares one byte-serial FNV-1a 32-bit hash engine between N_REQ requesters, for example I2C register-write streams and a self-test source.
- Arbitrates per message with round-robin priority and feeds the engine one byte per cycle.
- Presents each finished digest on a valid/ready output tagged with the requester id.
- Sits between the I2C peripheral byte sources and the register file / readback logic.

Parameters:
- N_REQ, 2, number of requesters (2..4).
- OFFSET_BASIS, 32'h811C9DC5, hash initial value.
- FNV_PRIME, 32'h01000193, FNV 32-bit prime.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- req_data  in  8*N_REQ  byte from requester i, at bits [8i+7:8i].
- req_valid  in  N_REQ  byte valid, one bit per requester.
- req_last  in  N_REQ  marks the final byte of a message.
- req_ready  out  N_REQ  byte accepted when valid&ready.
- dig_data  out  32  finished hash.
- dig_id  out  $clog2(N_REQ) (min 1)  requester that owns the digest.
- dig_valid  out  1  digest available.
- dig_ready  in  1  consumer accepts digest.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset takes priority over every other assignment:
  - state=IDLE, hash=OFFSET_BASIS, grant=0, rr_ptr=0.
  - req_ready=0, dig_valid=0, dig_data=0, dig_id=0, busy=0.
  - Reset mid-message or mid-digest abandons all work; no partial digest is ever emitted.
- FSM states are IDLE, HASH and DONE; all outputs are registered or decoded from state only.
- IDLE:
  - If any req_valid is high, pick the first requester with valid set, searching from rr_ptr upward with wrap-around.
  - Register the winner into grant and move to HASH next cycle.
  - req_ready is all-zero in IDLE, so no byte is consumed during the arbitration cycle.
- HASH:
  - req_ready[grant]=1; all other ready bits are 0.
  - On req_valid[grant] & ready: hash <= (hash ^ {24'b0, byte}) * FNV_PRIME, truncated mod 2^32.
  - If req_last[grant] is set on that beat, go to DONE.
  - Bubbles (valid low) hold hash and state indefinitely; there is no timeout.
  - Requesters other than grant are ignored and must hold their data.
- DONE:
  - dig_valid=1, dig_data=hash, dig_id=grant, held stable until dig_ready.
  - On dig_valid & dig_ready: hash <= OFFSET_BASIS, rr_ptr <= (grant+1) mod N_REQ, next state IDLE.
  - If dig_ready is high on the first DONE cycle, DONE lasts exactly one cycle.
- dig_data is 0 outside DONE.
- Throughput: 1 byte/cycle within a message. Minimum per-message overhead is 2 cycles (1 IDLE arbitration, 1 DONE).
- Latency: the digest is visible the cycle after the last byte handshake.
- Messages are at least 1 byte; zero-length messages are not expressible.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,N_REQ-1,0.
- A requester that raises valid while another message is active waits; its request is not lost, because valid is level-held.

Decomposition:
- Package fnv_pkg: OFFSET_BASIS and FNV_PRIME constants, the state enum (IDLE/HASH/DONE), and a function for one byte step of the hash.
- Sub-module fnv_1a_byte_step holds the hash register:
  - Inputs: clk, reset, init, en, byte.
  - Output: 32-bit hash.
  - reset/init load OFFSET_BASIS; en applies one step.
  - The top level owns arbitration and the FSM only.

Test Plan:
- Single byte "a" (0x61) from req0 with last=1, dig_ready=1 -> dig_data=0xE40C292C, dig_id=0, dig_valid for 1 cycle, 2 cycles after the byte handshake returns busy=0.
- "foobar" from req1, with valid low for 3 cycles between 'o' and 'b' -> dig_data=0xBF9CF968, dig_id=1; hash unchanged during the bubbles.
- req0 and req1 valid in the same IDLE cycle, each sending "a" then "b", repeated twice -> grant order 0,1,0,1.
  - Digests alternate 0xE40C292C (id0) and 0xE70C2DE5 (id1).
  - Non-granted req_ready stays 0 throughout.
- dig_ready held low 5 cycles after "a" -> dig_valid, dig_data and dig_id stable all 5 cycles; no req_ready asserted; the next message hashes from OFFSET_BASIS.
- reset asserted after 3 bytes of "foobar", then "a" sent after release -> no digest from the aborted message; the "a" digest equals 0xE40C292C and rr_ptr restarts at req0.
- Back-to-back messages on req0 only ("a" then "a") -> both digests are 0xE40C292C, confirming hash reinitialises after each digest handshake.
